// File: rtl/hack_boot_ctrl.sv
// hack_boot_ctrl: boot sequencer for the Hack CPU.
// Receives a framed program image from the UART byte stream, writes each
// 16-bit word into the instruction ROM, verifies an XOR checksum and only
// then releases the CPU from reset. A boot request pulse forces a reload.
module hack_boot_ctrl #(
    parameter int DEPTH   = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             boot_req,
    output logic             rom_we,
    output logic [DEPTH-1:0] rom_waddr,
    output logic [15:0]      rom_wdata,
    output logic             cpu_rst,
    output logic             o_busy,
    output logic             o_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CSUM    = 3'd5,
        S_RUN     = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    // Timeout counter saturates at TIMEOUT, so it needs room for that value.
    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
    // Largest legal word count; compared in 17 bits so 2^16 would still fit.
    localparam logic [16:0] MAX_WORDS = 17'(64'd1 << DEPTH);

    state_t             state_q, state_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [15:0]        len_q, len_d;
    logic [DEPTH:0]     wcnt_q, wcnt_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         hi_q, hi_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               rom_we_q, rom_we_d;
    logic [DEPTH-1:0]   rom_waddr_q, rom_waddr_d;
    logic [15:0]        rom_wdata_q, rom_wdata_d;
    logic               in_ready_q, in_ready_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               accept;
    logic               loading;
    logic [15:0]        len_word;
    logic [16:0]        wcnt_inc;

    // A byte transfers only when the registered ready is high.
    assign accept  = in_valid && in_ready_q;
    assign loading = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                     (state_q == S_CSUM);

    // Next-state and datapath decode; boot request beats a byte, a byte beats the timeout.
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        csum_d      = csum_q;
        hi_d        = hi_q;
        tcnt_d      = tcnt_q;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
        len_word    = {len_hi_q, in_data};
        wcnt_inc    = 17'(wcnt_q) + 17'd1;

        if (loading && (tcnt_q != TO_LIMIT)) begin
            tcnt_d = tcnt_q + TW'(1);
        end
        if (accept) begin
            tcnt_d = '0;
        end

        if (boot_req && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d  = len_word;
                    wcnt_d = '0;
                    csum_d = '0;
                    if ({1'b0, len_word} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_word == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    csum_d      = csum_q ^ in_data;
                    rom_we_d    = 1'b1;
                    rom_waddr_d = wcnt_q[DEPTH-1:0];
                    rom_wdata_d = {hi_q, in_data};
                    wcnt_d      = wcnt_inc[DEPTH:0];
                    if (wcnt_inc == {1'b0, len_q}) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_CSUM: begin
                    if (in_data == csum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                S_ERROR: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = S_LEN_HI;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (loading && (tcnt_q == TO_LIMIT)) begin
            state_d = S_ERROR;
        end

        // Status outputs are registered decodes of the upcoming state.
        in_ready_d = (state_d != S_RUN);
        cpu_rst_d  = (state_d != S_RUN);
        busy_d     = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                     (state_d == S_CSUM);
        err_d      = (state_d == S_ERROR);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath, ROM write port and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi_q    <= '0;
            len_q       <= '0;
            wcnt_q      <= '0;
            csum_q      <= '0;
            hi_q        <= '0;
            tcnt_q      <= '0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= '0;
            in_ready_q  <= 1'b1;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            csum_q      <= csum_d;
            hi_q        <= hi_d;
            tcnt_q      <= tcnt_d;
            rom_we_q    <= rom_we_d;
            rom_waddr_q <= rom_waddr_d;
            rom_wdata_q <= rom_wdata_d;
            in_ready_q  <= in_ready_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign o_busy    = busy_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Testbench for hack_boot_ctrl: frame-level scenarios with a ROM write scoreboard.
module tb_hack_boot_ctrl;

    localparam int DEPTH   = 14;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             boot_req;
    logic             rom_we;
    logic [DEPTH-1:0] rom_waddr;
    logic [15:0]      rom_wdata;
    logic             cpu_rst;
    logic             o_busy;
    logic             o_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DEPTH+15:0] exp_q[$];
    logic [15:0]       words[$];
    logic [DEPTH-1:0]  last_addr;

    hack_boot_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .boot_req (boot_req),
        .rom_we   (rom_we),
        .rom_waddr(rom_waddr),
        .rom_wdata(rom_wdata),
        .cpu_rst  (cpu_rst),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM write monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rom_write_unexpected: got addr=%h data=%h, expected no write", rom_waddr, rom_wdata);
            end else begin
                logic [DEPTH+15:0] e;
                e = exp_q.pop_front();
                if ({rom_waddr, rom_wdata} !== e) begin
                    tests_failed++;
                    $display("FAIL rom_write: got addr=%h data=%h, expected addr=%h data=%h",
                             rom_waddr, rom_wdata, e[DEPTH+15:16], e[15:0]);
                end
            end
            last_addr = rom_waddr;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
    endtask

    // Sends a full frame from the words queue; csum_flip corrupts the checksum.
    task automatic send_frame(input logic [7:0] csum_flip);
        logic [7:0]  cs;
        logic [15:0] n;
        cs = 8'h00;
        n  = 16'(words.size());
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < words.size(); i++) begin
            send_byte(words[i][15:8]);
            exp_q.push_back({DEPTH'(i), words[i]});
            send_byte(words[i][7:0]);
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
            tests_run++;
            if (rom_we !== 1'b1) begin
                tests_failed++;
                $display("FAIL rom_we_timing word %0d: got %b, expected 1", i, rom_we);
            end
        end
        send_byte(cs ^ csum_flip);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic check_queue_empty(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: %0d ROM writes missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        boot_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_cpu_rst", cpu_rst, 1'b1);
        check_bit("reset_rom_we", rom_we, 1'b0);
        check_bit("reset_busy", o_busy, 1'b0);
        check_bit("reset_err", o_err, 1'b0);
        tests_run++;
        if ({rom_waddr, rom_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_rom_port: got addr=%h data=%h, expected 0", rom_waddr, rom_wdata);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        words.delete();
        words.push_back(16'h1234);
        words.push_back(16'hABCD);
        send_frame(8'h00);
        check_bit("good_cpu_released", cpu_rst, 1'b0);
        check_bit("good_err", o_err, 1'b0);
        check_bit("good_in_ready_run", in_ready, 1'b0);
        check_queue_empty("good_writes");
    endtask

    task automatic test_bad_csum();
        pulse_boot();
        check_bit("boot_cpu_held", cpu_rst, 1'b1);
        send_frame(8'h01);
        check_queue_empty("bad_writes");
        check_bit("bad_err", o_err, 1'b1);
        check_bit("bad_cpu_held", cpu_rst, 1'b1);
        check_bit("bad_busy", o_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_bit("bad_err_sticky", o_err, 1'b1);
        words.delete();
        words.push_back(16'h5A3C);
        send_byte(8'h77);
        check_bit("err_ignores_junk", o_err, 1'b1);
        send_frame(8'h00);
        check_bit("recover_err_clear", o_err, 1'b0);
        check_bit("recover_cpu_released", cpu_rst, 1'b0);
        check_queue_empty("recover_writes");
    endtask

    task automatic test_len_bounds();
        pulse_boot();
        send_byte(8'h3C);
        check_bit("idle_discard", o_busy, 1'b0);
        words.delete();
        send_frame(8'h00);
        check_bit("zero_len_run", cpu_rst, 1'b0);
        pulse_boot();
        send_byte(8'hA5);
        send_byte(8'h40);
        check_bit("oversize_pending", o_err, 1'b0);
        send_byte(8'h01);
        check_bit("oversize_err", o_err, 1'b1);
        check_bit("oversize_cpu_held", cpu_rst, 1'b1);
    endtask

    task automatic test_full_depth();
        pulse_boot();
        words.delete();
        for (int i = 0; i < (1 << DEPTH); i++) begin
            words.push_back(16'(i * 37) ^ 16'hC3A5);
        end
        send_frame(8'h00);
        check_queue_empty("full_writes");
        tests_run++;
        if (last_addr !== DEPTH'((1 << DEPTH) - 1)) begin
            tests_failed++;
            $display("FAIL full_last_addr: got %h, expected %h", last_addr, DEPTH'((1 << DEPTH) - 1));
        end
        check_bit("full_cpu_released", cpu_rst, 1'b0);
    endtask

    task automatic test_timeout();
        pulse_boot();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TIMEOUT) @(posedge clk);
        #1;
        check_bit("timeout_not_yet", o_err, 1'b0);
        exp_q.push_back({DEPTH'(0), 16'h1234});
        send_byte(8'h34);
        check_bit("timeout_byte_wins", o_busy, 1'b1);
        send_byte(8'h12 ^ 8'h34);
        check_bit("timeout_frame_done", cpu_rst, 1'b0);
        check_queue_empty("timeout_writes");
        pulse_boot();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TIMEOUT) @(posedge clk);
        #1;
        check_bit("timeout_edge_minus1", o_err, 1'b0);
        @(posedge clk);
        #1;
        check_bit("timeout_err", o_err, 1'b1);
        check_bit("timeout_cpu_held", cpu_rst, 1'b1);
    endtask

    task automatic test_run_and_reset();
        pulse_boot();
        check_bit("boot_from_err_clear", o_err, 1'b0);
        words.delete();
        words.push_back(16'h0F0F);
        send_frame(8'h00);
        in_valid = 1'b1;
        in_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_bit("run_in_ready", in_ready, 1'b0);
            check_bit("run_cpu_free", cpu_rst, 1'b0);
        end
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
        check_bit("run_boot_cpu_rst", cpu_rst, 1'b1);
        check_bit("run_boot_idle", o_busy, 1'b0);
        @(posedge clk);
        #1;
        check_bit("pending_sync_taken", o_busy, 1'b1);
        boot_req = 1'b1;
        in_data = 8'h00;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
        in_valid = 1'b0;
        check_bit("boot_beats_byte", o_busy, 1'b0);
        words.delete();
        words.push_back(16'hBEEF);
        send_frame(8'h00);
        check_bit("reload_cpu_released", cpu_rst, 1'b0);
        check_queue_empty("reload_writes");
        #2;
        rst = 1'b0;
        #1;
        check_bit("async_rst_cpu_held", cpu_rst, 1'b1);
        check_bit("async_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        in_valid = 1'b1;
        in_data = 8'h22;
        #2;
        rst = 1'b0;
        #1;
        check_bit("midlo_rst_busy", o_busy, 1'b0);
        check_bit("midlo_rst_we", rom_we, 1'b0);
        check_bit("midlo_rst_err", o_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({rom_waddr, rom_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL midlo_rst_rom_port: got addr=%h data=%h, expected 0", rom_waddr, rom_wdata);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("after_rst_idle", o_busy, 1'b0);
        check_queue_empty("final_writes");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len_bounds();
        test_full_depth();
        test_timeout();
        test_run_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
